lemmings_fsm_param: RTL and testbench

- Parametrised successor of the two-state walk-left/walk-right lemming controller.
- Adds falling (ground loss), digging, and splatting after an over-long fall; the splat threshold is a parameter.
- Moore-style FSM with a saturating fall counter.
- Sits in the lemmings game logic as the per-lemming behaviour controller driven by the terrain sensors.

---
 rtl/lemmings_pkg.sv | 49 ++++
 rtl/lemmings_fall_counter.sv | 33 +++
 rtl/lemmings_fsm_param.sv | 87 ++++++++
 tb/tb_lemmings_fsm_param.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/lemmings_pkg.sv
// Shared definitions for the lemming behaviour controllers: state encoding,
// the per-state output bundle and the Moore output decoder.
package lemmings_pkg;

    localparam int STATE_W = 3;

    // Raw state codes, shared with multi-lemming arrays and the display block.
    localparam logic [STATE_W-1:0] ST_WALK_L = 3'd0;
    localparam logic [STATE_W-1:0] ST_WALK_R = 3'd1;
    localparam logic [STATE_W-1:0] ST_FALL_L = 3'd2;
    localparam logic [STATE_W-1:0] ST_FALL_R = 3'd3;
    localparam logic [STATE_W-1:0] ST_DIG_L  = 3'd4;
    localparam logic [STATE_W-1:0] ST_DIG_R  = 3'd5;
    localparam logic [STATE_W-1:0] ST_SPLAT  = 3'd6;

    typedef enum logic [STATE_W-1:0] {
        WALK_L = ST_WALK_L,
        WALK_R = ST_WALK_R,
        FALL_L = ST_FALL_L,
        FALL_R = ST_FALL_R,
        DIG_L  = ST_DIG_L,
        DIG_R  = ST_DIG_R,
        SPLAT  = ST_SPLAT
    } state_e;

    typedef struct packed {
        logic walk_left;
        logic walk_right;
        logic aaah;
        logic digging;
        logic splat;
    } outs_t;

    // Exactly one output is high per state; the unused code decodes to all-zero.
    function automatic outs_t decode_state(input state_e s);
        outs_t o;
        o = '0;
        case (s)
            WALK_L:        o.walk_left  = 1'b1;
            WALK_R:        o.walk_right = 1'b1;
            FALL_L, FALL_R: o.aaah      = 1'b1;
            DIG_L, DIG_R:  o.digging    = 1'b1;
            SPLAT:         o.splat      = 1'b1;
            default:       o            = '0;
        endcase
        return o;
    endfunction

endpackage

// File: rtl/lemmings_fall_counter.sv
// Saturating fall-length counter: counts ground-less cycles while falling,
// sticks at MAX_VAL, and flags when the survivable fall length is used up.
module lemmings_fall_counter #(
    parameter int MAX_VAL = 20,
    parameter int CNT_W   = $clog2(MAX_VAL + 1)
) (
    input  logic clk,
    input  logic areset,
    input  logic clr_i,
    input  logic en_i,
    output logic sat_reached_o
);

    localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_VAL);

    logic [CNT_W-1:0] cnt_q;

    // Clear has priority over counting; counting stops at MAX_CNT (no wrap).
    always_ff @(posedge clk or posedge areset) begin
        // NOTE: state registers use non-blocking assignments so every flop
        // samples pre-edge values regardless of block ordering.
        if (areset) begin
            cnt_q <= '0;
        end else if (clr_i) begin
            cnt_q <= '0;
        end else if (en_i && (cnt_q < MAX_CNT)) begin
            cnt_q <= cnt_q + CNT_W'(1);
        end
    end

    assign sat_reached_o = (cnt_q >= MAX_CNT);

endmodule

// File: rtl/lemmings_fsm_param.sv
// Per-lemming behaviour controller: walk, fall, dig and splat, with the
// fatal fall length set by SPLAT_CYCLES. Outputs are registered (Moore).
module lemmings_fsm_param
    import lemmings_pkg::*;
#(
    parameter int SPLAT_CYCLES = 20,
    parameter int CNT_W        = $clog2(SPLAT_CYCLES + 1)
) (
    input  logic clk,
    input  logic areset,
    input  logic bump_left,
    input  logic bump_right,
    input  logic ground,
    input  logic dig,
    output logic walk_left,
    output logic walk_right,
    output logic aaah,
    output logic digging,
    output logic splat
);

    state_e state_q;
    state_e state_d;
    outs_t  outs_q;
    logic   falling;
    logic   fall_en;
    logic   sat_reached;

    // The counter only runs while falling; any other state holds it at zero.
    assign falling = (state_q == FALL_L) || (state_q == FALL_R);
    assign fall_en = falling && !ground;

    lemmings_fall_counter #(
        .MAX_VAL (SPLAT_CYCLES),
        .CNT_W   (CNT_W)
    ) u_fall_counter (
        .clk           (clk),
        .areset        (areset),
        .clr_i         (!falling),
        .en_i          (fall_en),
        .sat_reached_o (sat_reached)
    );

    // Next-state rules: losing ground beats digging, digging beats bumping.
    always_comb begin
        // NOTE: hold-by-default assignment first, so no path leaves state_d
        // unassigned and no latch is inferred.
        state_d = state_q;
        case (state_q)
            WALK_L: begin
                if (!ground)        state_d = FALL_L;
                else if (dig)       state_d = DIG_L;
                else if (bump_left) state_d = WALK_R;
            end
            WALK_R: begin
                if (!ground)         state_d = FALL_R;
                else if (dig)        state_d = DIG_R;
                else if (bump_right) state_d = WALK_L;
            end
            FALL_L: if (ground) state_d = sat_reached ? SPLAT : WALK_L;
            FALL_R: if (ground) state_d = sat_reached ? SPLAT : WALK_R;
            DIG_L:  if (!ground) state_d = FALL_L;
            DIG_R:  if (!ground) state_d = FALL_R;
            SPLAT:  state_d = SPLAT;
            default: state_d = WALK_L;
        endcase
    end

    // State and decoded outputs are registered together, so no input reaches
    // an output combinationally.
    always_ff @(posedge clk or posedge areset) begin
        if (areset) begin
            state_q <= WALK_L;
            outs_q  <= decode_state(WALK_L);
        end else begin
            state_q <= state_d;
            outs_q  <= decode_state(state_d);
        end
    end

    assign walk_left  = outs_q.walk_left;
    assign walk_right = outs_q.walk_right;
    assign aaah       = outs_q.aaah;
    assign digging    = outs_q.digging;
    assign splat      = outs_q.splat;

endmodule

// File: tb/tb_lemmings_fsm_param.sv
// Bench for lemmings_fsm_param: two instances (SPLAT_CYCLES 20 and 3) share
// stimulus; a fall-length model checks every cycle, directed scenarios pin it.
module tb_lemmings_fsm_param;

    logic clk = 1'b0;
    logic areset, bump_left, bump_right, ground, dig;
    logic [1:0] wl, wr, ah, dg, sp;

    lemmings_fsm_param #(.SPLAT_CYCLES(20)) u_dut20 (
        .clk(clk), .areset(areset), .bump_left(bump_left), .bump_right(bump_right),
        .ground(ground), .dig(dig), .walk_left(wl[0]), .walk_right(wr[0]),
        .aaah(ah[0]), .digging(dg[0]), .splat(sp[0])
    );

    lemmings_fsm_param #(.SPLAT_CYCLES(3)) u_dut3 (
        .clk(clk), .areset(areset), .bump_left(bump_left), .bump_right(bump_right),
        .ground(ground), .dig(dig), .walk_left(wl[1]), .walk_right(wr[1]),
        .aaah(ah[1]), .digging(dg[1]), .splat(sp[1])
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // Behavioural model: activity, facing, and how many aaah cycles the
    // current fall has produced so far.
    typedef enum {M_WALK, M_FALL, M_DIG, M_DEAD} mode_e;
    mode_e m_mode[2];
    bit    m_right[2];
    int    m_fall_len[2];
    int    m_limit[2] = '{20, 3};

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic void m_reset();
        for (int i = 0; i < 2; i++) begin
            m_mode[i]     = M_WALK;
            m_right[i]    = 1'b0;
            m_fall_len[i] = 0;
        end
    endfunction

    function automatic void m_step(int i, logic g, logic d, logic bl, logic br);
        case (m_mode[i])
            M_WALK: begin
                if (!g) begin
                    m_mode[i] = M_FALL;
                    m_fall_len[i] = 1;
                end else if (d) begin
                    m_mode[i] = M_DIG;
                end else if (m_right[i] ? br : bl) begin
                    m_right[i] = !m_right[i];
                end
            end
            M_FALL: begin
                if (!g) m_fall_len[i]++;
                else    m_mode[i] = (m_fall_len[i] <= m_limit[i]) ? M_WALK : M_DEAD;
            end
            M_DIG: begin
                if (!g) begin
                    m_mode[i] = M_FALL;
                    m_fall_len[i] = 1;
                end
            end
            default: ;
        endcase
    endfunction

    // Compare process: advance the model on each edge, check 1ns later.
    always begin
        @(posedge clk);
        if (!areset) begin
            for (int i = 0; i < 2; i++) m_step(i, ground, dig, bump_left, bump_right);
        end
        #1;
        for (int i = 0; i < 2; i++) begin
            check($sformatf("dut%0d walk_left", i),  wl[i], m_mode[i] == M_WALK && !m_right[i]);
            check($sformatf("dut%0d walk_right", i), wr[i], m_mode[i] == M_WALK && m_right[i]);
            check($sformatf("dut%0d aaah", i),       ah[i], m_mode[i] == M_FALL);
            check($sformatf("dut%0d digging", i),    dg[i], m_mode[i] == M_DIG);
            check($sformatf("dut%0d splat", i),      sp[i], m_mode[i] == M_DEAD);
        end
    end

    task automatic idle_inputs();
        ground = 1'b1; dig = 1'b0; bump_left = 1'b0; bump_right = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        areset = 1'b1;
        m_reset();
        idle_inputs();
        @(negedge clk);
        areset = 1'b0;
    endtask

    // Hold ground low for k input cycles (k aaah cycles), then land.
    task automatic fall_for(input int k, input logic bumps, input logic d, output int seen);
        seen = 0;
        ground = 1'b0; bump_left = bumps; bump_right = bumps; dig = d;
        repeat (k) begin
            @(negedge clk);
            if (ah[0] === 1'b1) seen++;
        end
        idle_inputs();
        @(negedge clk);
    endtask

    int seen;
    int burst;

    initial begin
        areset = 1'b1;
        idle_inputs();
        m_reset();
        @(negedge clk);
        @(negedge clk);
        check("reset walk_left dut20", wl[0], 1);
        check("reset walk_left dut3", wl[1], 1);
        check("reset others dut20", {wr[0], ah[0], dg[0], sp[0]}, 0);
        areset = 1'b0;

        // Steady walking, then bumps in each direction and both at once.
        repeat (5) begin
            @(negedge clk);
            check("hold walk_left", wl[0], 1);
        end
        bump_left = 1'b1; @(negedge clk); bump_left = 1'b0;
        check("bump_left turns", wr[0], 1);
        bump_right = 1'b1; @(negedge clk); bump_right = 1'b0;
        check("bump_right turns", wl[0], 1);
        bump_left = 1'b1; bump_right = 1'b1; @(negedge clk); idle_inputs();
        check("both bumps reverse", wr[0], 1);

        // Short fall from WALK_R with bumps and dig asserted: direction kept.
        fall_for(3, 1'b1, 1'b1, seen);
        check("short fall aaah count", seen, 3);
        check("short fall keeps right dut20", wr[0], 1);
        check("fall of 3 survives dut3", wr[1], 1);

        // Longest survivable fall for 20; fatal for 3.
        do_reset();
        fall_for(20, 1'b0, 1'b0, seen);
        check("fall 20 aaah count", seen, 20);
        check("fall 20 survives dut20", wl[0], 1);
        check("fall 20 splats dut3", sp[1], 1);

        // One cycle longer is fatal, and SPLAT ignores everything after.
        do_reset();
        fall_for(21, 1'b0, 1'b0, seen);
        check("fall 21 aaah count", seen, 21);
        check("fall 21 splats dut20", sp[0], 1);
        repeat (20) begin
            ground = 1'($urandom_range(0, 1)); dig = 1'($urandom_range(0, 1));
            bump_left = 1'($urandom_range(0, 1)); bump_right = 1'($urandom_range(0, 1));
            @(negedge clk);
            check("splat is terminal", {sp[0], wl[0], wr[0], ah[0], dg[0]}, 5'b10000);
        end

        // Digging: immune to bumps, ends only by losing ground.
        do_reset();
        dig = 1'b1; @(negedge clk); dig = 1'b0;
        check("dig starts", dg[0], 1);
        bump_left = 1'b1; bump_right = 1'b1;
        repeat (10) begin
            @(negedge clk);
            check("dig ignores bumps", dg[0], 1);
        end
        fall_for(2, 1'b0, 1'b0, seen);
        check("dig fall aaah count", seen, 2);
        check("dig fall lands left", wl[0], 1);

        // Asynchronous reset mid-fall, then prove the counter was cleared.
        do_reset();
        ground = 1'b0;
        repeat (16) @(negedge clk);
        check("falling before reset", ah[0], 1);
        #2;
        areset = 1'b1;
        m_reset();
        idle_inputs();
        #1;
        check("async reset walk_left", wl[0], 1);
        check("async reset aaah", ah[0], 0);
        #1;
        areset = 1'b0;
        @(negedge clk);
        fall_for(20, 1'b0, 1'b0, seen);
        check("post-reset fall survives", wl[0], 1);

        do_reset();
        fall_for(4, 1'b0, 1'b0, seen);
        check("fall 4 splats dut3", sp[1], 1);
        check("fall 4 survives dut20", wl[0], 1);

        // Randomized traffic with ground-loss bursts and occasional resets.
        do_reset();
        burst = 0;
        for (int n = 0; n < 1500; n++) begin
            if (burst > 0) begin
                ground = 1'b0;
                burst--;
            end else if ($urandom_range(0, 99) < 6) begin
                ground = 1'b0;
                burst = $urandom_range(0, 24);
            end else begin
                ground = 1'b1;
            end
            dig        = ($urandom_range(0, 99) < 5);
            bump_left  = ($urandom_range(0, 99) < 30);
            bump_right = ($urandom_range(0, 99) < 30);
            if ($urandom_range(0, 199) == 0) begin
                #2;
                areset = 1'b1;
                m_reset();
                #1;
                areset = 1'b0;
            end
            @(negedge clk);
        end

        @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
